// File: rtl/control_rampa_corriente.sv
// Current-reference sequencer: buttons set a target code, Corriente ramps toward it one step per tick.
// Optional macro SALTO_DIRECTO_EN bypasses the ramp and loads the target straight into Corriente.
module control_rampa_corriente #(
    parameter int TICK_DIV = 1000,
    parameter int MAX_CODE = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       enable,
    output logic [3:0] Corriente,
    output logic [3:0] objetivo,
    output logic       ocupado
);
    localparam logic [3:0] MAX_C = 4'(MAX_CODE);

    logic [1:0] btn_now;
    logic [1:0] btn_ev;
    logic       armed_reg;
    logic [3:0] objetivo_reg;
    logic [3:0] objetivo_next;
    logic [3:0] corriente_reg;

    assign btn_now = {btn_down, btn_up};

    // Edges are masked on the first cycle after reset so a button held through reset is not a press
    always_ff @(posedge clk) begin
        if (reset) armed_reg <= 1'b0;
        else       armed_reg <= 1'b1;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            logic btn_q_reg;
            always_ff @(posedge clk) begin
                if (reset) btn_q_reg <= 1'b0;
                else       btn_q_reg <= btn_now[gi];
            end
            assign btn_ev[gi] = armed_reg & btn_now[gi] & ~btn_q_reg;
        end
    endgenerate

    // Simultaneous up and down events cancel; saturated requests leave the target alone
    always_comb begin
        objetivo_next = objetivo_reg;
        if (btn_ev == 2'b01 && objetivo_reg < MAX_C)
            objetivo_next = objetivo_reg + 4'd1;
        else if (btn_ev == 2'b10 && objetivo_reg != 4'd0)
            objetivo_next = objetivo_reg - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) objetivo_reg <= 4'd0;
        else       objetivo_reg <= objetivo_next;
    end

`ifdef SALTO_DIRECTO_EN
    always_ff @(posedge clk) begin
        if (reset)       corriente_reg <= 4'd0;
        else if (enable) corriente_reg <= objetivo_reg;
    end

    assign ocupado = 1'b0;
`else
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUBIR = 2'd1,
        BAJAR = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       corriente_next;
    logic             ocupado_reg;
    logic             tick;

    assign tick = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        corriente_next = corriente_reg;
        case (state_reg)
            IDLE: begin
                if (corriente_reg < objetivo_reg) begin
                    state_next = SUBIR;
                    cnt_next   = '0;
                end else if (corriente_reg > objetivo_reg) begin
                    state_next = BAJAR;
                    cnt_next   = '0;
                end
            end
            SUBIR: begin
                // A target change takes priority over a pending tick
                if (objetivo_reg < corriente_reg) begin
                    state_next = BAJAR;
                    cnt_next   = '0;
                end else if (objetivo_reg == corriente_reg) begin
                    state_next = IDLE;
                end else if (enable) begin
                    if (tick) begin
                        corriente_next = corriente_reg + 4'd1;
                        cnt_next       = '0;
                        if (corriente_reg + 4'd1 == objetivo_reg)
                            state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            BAJAR: begin
                if (objetivo_reg > corriente_reg) begin
                    state_next = SUBIR;
                    cnt_next   = '0;
                end else if (objetivo_reg == corriente_reg) begin
                    state_next = IDLE;
                end else if (enable) begin
                    if (tick) begin
                        corriente_next = corriente_reg - 4'd1;
                        cnt_next       = '0;
                        if (corriente_reg - 4'd1 == objetivo_reg)
                            state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            corriente_reg <= 4'd0;
            ocupado_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            corriente_reg <= corriente_next;
            ocupado_reg   <= (state_next != IDLE);
        end
    end

    assign ocupado = ocupado_reg;
`endif

    assign Corriente = corriente_reg;
    assign objetivo  = objetivo_reg;
endmodule

// File: tb/tb_control_rampa_corriente.sv
// Bench for control_rampa_corriente with TICK_DIV=4, MAX_CODE=10.
module tb_control_rampa_corriente;
    localparam int TICK_DIV = 4;
    localparam int MAX_CODE = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       enable;
    logic [3:0] Corriente;
    logic [3:0] objetivo;
    logic       ocupado;

    int total = 0;
    int bad   = 0;
    int max_corr = 0;
    int prev_corr = 0;
    int jumps = 0;

    control_rampa_corriente #(.TICK_DIV(TICK_DIV), .MAX_CODE(MAX_CODE)) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .enable(enable), .Corriente(Corriente), .objetivo(objetivo), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] corr;
        logic [3:0] obj;
        logic       ocup;
    } exp_t;

    typedef struct {
        logic       up;
        logic       dn;
        logic       en;
        logic [3:0] corr;
        logic [3:0] obj;
        logic       ocup;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[26];

    function automatic vec_t mk(input logic up, input logic dn, input logic en,
                                input logic [3:0] c, input logic [3:0] o, input logic oc);
        vec_t v;
        v.up = up; v.dn = dn; v.en = en; v.corr = c; v.obj = o; v.ocup = oc;
        return v;
    endfunction

    task automatic push_exp(input logic [3:0] c, input logic [3:0] o, input logic oc);
        exp_t e;
        e.corr = c; e.obj = o; e.ocup = oc;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got corr=%0d obj=%0d ocup=%0d", name, Corriente, objetivo, ocupado);
        end else begin
            e = sb_q.pop_front();
            if (Corriente !== e.corr || objetivo !== e.obj || ocupado !== e.ocup) begin
                bad++;
                $display("FAIL %s: got corr=%0d obj=%0d ocup=%0d expected corr=%0d obj=%0d ocup=%0d",
                         name, Corriente, objetivo, ocupado, e.corr, e.obj, e.ocup);
            end else begin
                $display("txn %s: corr=%0d obj=%0d ocup=%0d ok", name, Corriente, objetivo, ocupado);
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("txn %s: %0d ok", name, got);
        end
    endtask

    task automatic step(input logic up, input logic dn, input logic en);
        btn_up = up; btn_down = dn; enable = en;
        @(posedge clk);
        #1;
        if (int'(Corriente) > max_corr) max_corr = int'(Corriente);
        if (int'(Corriente) - prev_corr > 1 || prev_corr - int'(Corriente) > 1) jumps++;
        prev_corr = int'(Corriente);
    endtask

    task automatic wait_for(input string name, input logic [3:0] c, input logic oc, input int budget);
        int n;
        n = 0;
        while (!(Corriente == c && ocupado == oc) && n < budget) begin
            step(1'b0, 1'b0, 1'b1);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: timeout, got corr=%0d ocup=%0d expected corr=%0d ocup=%0d", name, Corriente, ocupado, c, oc);
        end else begin
            $display("txn %s: reached after %0d cycles", name, n);
        end
    endtask

    initial begin
        int exp_obj;

        // Reset with btn_up held
        reset = 1'b1; btn_up = 1'b1; btn_down = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp(4'd0, 4'd0, 1'b0);
            @(posedge clk); #1;
            pop_check($sformatf("reset_%0d", i));
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(4'd0, 4'd0, 1'b0);
            step(1'b1, 1'b0, 1'b1);
            pop_check($sformatf("held_after_reset_%0d", i));
        end
        push_exp(4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        pop_check("release");

`ifdef SALTO_DIRECTO_EN
        for (int k = 1; k <= 5; k++) begin
            push_exp(4'(k - 1), 4'(k), 1'b0);
            step(1'b1, 1'b0, 1'b1);
            pop_check($sformatf("salto_press_%0d", k));
            push_exp(4'(k), 4'(k), 1'b0);
            step(1'b0, 1'b0, 1'b1);
            pop_check($sformatf("salto_follow_%0d", k));
        end
`else
        // Per-cycle vectors: three-pulse ramp, simultaneous press, enable freeze
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1);
        vecs[2]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 1'b1);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 1'b1);
        vecs[4]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd3, 1'b1);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0);
        vecs[15] = mk(1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0);
        vecs[17] = mk(1'b1, 1'b0, 1'b1, 4'd3, 4'd4, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 4'd3, 4'd4, 1'b1);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 4'd3, 4'd4, 1'b1);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 4'd3, 4'd4, 1'b1);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 4'd3, 4'd4, 1'b1);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 4'd3, 4'd4, 1'b1);
        vecs[23] = mk(1'b0, 1'b0, 1'b1, 4'd3, 4'd4, 1'b1);
        vecs[24] = mk(1'b0, 1'b0, 1'b1, 4'd3, 4'd4, 1'b1);
        vecs[25] = mk(1'b0, 1'b0, 1'b1, 4'd4, 4'd4, 1'b0);

        for (int i = 0; i < 26; i++) begin
            push_exp(vecs[i].corr, vecs[i].obj, vecs[i].ocup);
            step(vecs[i].up, vecs[i].dn, vecs[i].en);
            pop_check($sformatf("vec_%0d", i));
        end

        // Saturation at MAX_CODE going up, at 0 going down
        exp_obj = 4;
        max_corr = 0; jumps = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (exp_obj < MAX_CODE) exp_obj++;
            check_val($sformatf("sat_up_obj_%0d", k), int'(objetivo), exp_obj);
            step(1'b0, 1'b0, 1'b1);
        end
        wait_for("sat_up_ramp", 4'd10, 1'b0, 300);
        check_val("sat_up_corr", int'(Corriente), 10);
        check_val("sat_up_max_corr", max_corr, 10);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 1'b1);
            if (exp_obj > 0) exp_obj--;
            check_val($sformatf("sat_dn_obj_%0d", k), int'(objetivo), exp_obj);
            step(1'b0, 1'b0, 1'b1);
        end
        wait_for("sat_dn_ramp", 4'd0, 1'b0, 300);
        check_val("sat_dn_obj", int'(objetivo), 0);
        check_val("sat_max_corr", max_corr, 10);
        check_val("sat_jumps", jumps, 0);

        // Reversal: ramp toward 6, freeze at 3, drop target to 1
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
        end
        check_val("rev_obj6", int'(objetivo), 6);
        wait_for("rev_reach3", 4'd3, 1'b1, 100);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        push_exp(4'd3, 4'd1, 1'b1);
        pop_check("rev_frozen");
        for (int k = 0; k < 3; k++) begin
            push_exp(4'd3, 4'd1, 1'b1);
            step(1'b0, 1'b0, 1'b1);
            pop_check($sformatf("rev_wait_a%0d", k));
        end
        push_exp(4'd2, 4'd1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        pop_check("rev_step2");
        for (int k = 0; k < 3; k++) begin
            push_exp(4'd2, 4'd1, 1'b1);
            step(1'b0, 1'b0, 1'b1);
            pop_check($sformatf("rev_wait_b%0d", k));
        end
        push_exp(4'd1, 4'd1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        pop_check("rev_step1");

        // Reset in the middle of a ramp
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
        end
        wait_for("midreset_reach2", 4'd2, 1'b1, 100);
        reset = 1'b1;
        push_exp(4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        pop_check("midreset");
        reset = 1'b0;
        push_exp(4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        pop_check("after_midreset");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
